// File: rtl/param_streamer_pkg.sv
// Shared constants, state encoding and helpers for the parameter streamer.
package param_streamer_pkg;

    // First byte of every frame, lets a sink resynchronise.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Index counter width; the longest legal frame is 3+4+4+16 = 27 bytes.
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of whole bytes needed to carry a field of the given bit width.
    function automatic int byte_count(input int bits);
        return (bits + 32'sd7) / 32'sd8;
    endfunction

    // Flags byte: per-parameter match results plus the two single-bit values.
    function automatic logic [7:0] flags_byte(input logic vec_ok, input logic int_ok,
                                             input logic rea_ok, input logic str_ok,
                                             input logic log_v,  input logic boo_v);
        return {2'b00, vec_ok, int_ok, rea_ok, str_ok, log_v, boo_v};
    endfunction

endpackage

// File: rtl/param_frame_rom.sv
// Constant frame contents (everything except the checksum), indexed by byte
// position. All comparisons are resolved at elaboration.
module param_frame_rom
    import param_streamer_pkg::*;
#(
    parameter int                   BOO     = 0,
    parameter int                   INT_W   = 8,
    parameter logic [INT_W-1:0]     INT     = '0,
    parameter logic                 LOG     = 1'b0,
    parameter int                   VEC_W   = 8,
    parameter logic [VEC_W-1:0]     VEC     = '0,
    parameter int                   STR_LEN = 4,
    parameter logic [8*STR_LEN-1:0] STR     = "ABCD",
    parameter real                  REA     = 0.0,
    parameter logic [INT_W-1:0]     EXP_INT = INT_W'(32'd255),
    parameter logic [VEC_W-1:0]     EXP_VEC = '1,
    parameter logic [8*STR_LEN-1:0] EXP_STR = "WXYZ",
    parameter real                  EXP_REA = 1.1
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       byte_o,
    output logic             match_o
);

    localparam int IB = byte_count(INT_W);
    localparam int VB = byte_count(VEC_W);
    localparam int NB = 2 + IB + VB + STR_LEN;

    localparam logic BOO_B  = BOO[0];
    localparam logic INT_OK = (INT == EXP_INT);
    localparam logic VEC_OK = (VEC == EXP_VEC);
    localparam logic STR_OK = (STR == EXP_STR);
    localparam logic REA_OK = (REA == EXP_REA);

    localparam logic [7:0]      FLAGS   = flags_byte(VEC_OK, INT_OK, REA_OK, STR_OK, LOG, BOO_B);
    localparam logic [8*IB-1:0] INT_EXT = (8*IB)'(INT);
    localparam logic [8*VB-1:0] VEC_EXT = (8*VB)'(VEC);

    // Byte 0 sits in the top byte, so the string keeps its first character first.
    localparam logic [8*NB-1:0] FRAME = {SYNC_BYTE, FLAGS, INT_EXT, VEC_EXT, STR};

    assign match_o = BOO_B & LOG & INT_OK & VEC_OK & STR_OK & REA_OK;

    // One-hot mux over the constant frame; out-of-range indices read as zero.
    always_comb begin
        byte_o = 8'h00;
        for (int k = 0; k < NB; k++) begin
            byte_o = byte_o | ((idx_i == IDX_W'(k)) ? FRAME[8*(NB-1-k) +: 8] : 8'h00);
        end
    end

endmodule

// File: rtl/param_streamer.sv
// Streams the compile-time parameter values and their match flags as a
// checksummed byte frame over a valid/ready interface.
module param_streamer
    import param_streamer_pkg::*;
#(
    parameter int                   BOO     = 0,
    parameter int                   INT_W   = 8,
    parameter logic [INT_W-1:0]     INT     = '0,
    parameter logic                 LOG     = 1'b0,
    parameter int                   VEC_W   = 8,
    parameter logic [VEC_W-1:0]     VEC     = '0,
    parameter int                   STR_LEN = 4,
    parameter logic [8*STR_LEN-1:0] STR     = "ABCD",
    parameter real                  REA     = 0.0,
    parameter logic [INT_W-1:0]     EXP_INT = INT_W'(32'd255),
    parameter logic [VEC_W-1:0]     EXP_VEC = '1,
    parameter logic [8*STR_LEN-1:0] EXP_STR = "WXYZ",
    parameter real                  EXP_REA = 1.1,
    parameter int                   REPEAT  = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic [7:0] tdata_o,
    output logic       tvalid_o,
    input  logic       tready_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       match_o
);

    localparam int               N_BYTES  = 3 + byte_count(INT_W) + byte_count(VEC_W) + STR_LEN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic             REPEAT_B = (REPEAT != 0);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [IDX_W-1:0] next_idx_s;
    logic [7:0]       rom_byte_s;
    logic             hs_s;

    assign next_idx_s = idx_q + IDX_W'(1);
    assign hs_s       = tvalid_q & tready_i;

    param_frame_rom #(
        .BOO(BOO), .INT_W(INT_W), .INT(INT), .LOG(LOG), .VEC_W(VEC_W), .VEC(VEC),
        .STR_LEN(STR_LEN), .STR(STR), .REA(REA), .EXP_INT(EXP_INT), .EXP_VEC(EXP_VEC),
        .EXP_STR(EXP_STR), .EXP_REA(EXP_REA)
    ) u_rom (
        .idx_i   (next_idx_s),
        .byte_o  (rom_byte_s),
        .match_o (match_o)
    );

    // Next-state logic: the output register always holds the byte at idx_q.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = SEND;
                    idx_d    = '0;
                    csum_d   = 8'h00;
                    tdata_d  = SYNC_BYTE;
                    tvalid_d = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    tvalid_d = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            SEND: begin
                if (hs_s) begin
                    csum_d = csum_q ^ tdata_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        if (REPEAT_B) begin
                            // Next frame's sync byte goes out alongside done_o.
                            tdata_d  = SYNC_BYTE;
                            tvalid_d = 1'b1;
                            csum_d   = 8'h00;
                        end else begin
                            tdata_d  = 8'h00;
                            tvalid_d = 1'b0;
                        end
                    end else begin
                        idx_d = next_idx_s;
                        if (next_idx_s == LAST_IDX) begin
                            tdata_d = csum_q ^ tdata_q;
                        end else begin
                            tdata_d = rom_byte_s;
                        end
                    end
                end else begin
                    state_d = SEND;
                end
            end
            DONE: begin
                if (REPEAT_B) begin
                    // Sync byte may already be accepted during the done cycle.
                    state_d = SEND;
                    if (hs_s) begin
                        csum_d  = csum_q ^ tdata_q;
                        idx_d   = next_idx_s;
                        tdata_d = rom_byte_s;
                    end else begin
                        idx_d = idx_q;
                    end
                end else begin
                    state_d  = IDLE;
                    tvalid_d = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                idx_d    = '0;
                csum_d   = 8'h00;
                tdata_d  = 8'h00;
                tvalid_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State, index, checksum and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            csum_q   <= 8'h00;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tdata_o  = tdata_q;
    assign tvalid_o = tvalid_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_param_streamer.sv
// Bench for param_streamer: four parameterisations checked against a frame
// model built directly from the parameter values.
module tb_param_streamer;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rstn_s, start_s, ready_s, tvalid_s, busy_s, done_s, match_s;
    logic [7:0] tdata_s [4];

    int n_cmp = 0;
    int n_err = 0;

    // 0: all parameters match
    param_streamer #(.BOO(1), .INT(8'd255), .LOG(1'b1), .VEC(8'hFF), .STR("WXYZ"), .REA(1.1)) u_match (
        .clk_i(clk), .rst_ni(rstn_s[0]), .start_i(start_s[0]), .tdata_o(tdata_s[0]),
        .tvalid_o(tvalid_s[0]), .tready_i(ready_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]),
        .match_o(match_s[0]));

    // 1: defaults, nothing matches
    param_streamer u_def (
        .clk_i(clk), .rst_ni(rstn_s[1]), .start_i(start_s[1]), .tdata_o(tdata_s[1]),
        .tvalid_o(tvalid_s[1]), .tready_i(ready_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]),
        .match_o(match_s[1]));

    // 2: 12-bit integer field
    param_streamer #(.INT_W(12), .INT(12'hABC)) u_wide (
        .clk_i(clk), .rst_ni(rstn_s[2]), .start_i(start_s[2]), .tdata_o(tdata_s[2]),
        .tvalid_o(tvalid_s[2]), .tready_i(ready_s[2]), .busy_o(busy_s[2]), .done_o(done_s[2]),
        .match_o(match_s[2]));

    // 3: all match, back-to-back frames
    param_streamer #(.BOO(1), .INT(8'd255), .LOG(1'b1), .VEC(8'hFF), .STR("WXYZ"), .REA(1.1),
                     .REPEAT(1)) u_rep (
        .clk_i(clk), .rst_ni(rstn_s[3]), .start_i(start_s[3]), .tdata_o(tdata_s[3]),
        .tvalid_o(tvalid_s[3]), .tready_i(ready_s[3]), .busy_o(busy_s[3]), .done_o(done_s[3]),
        .match_o(match_s[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame from the parameter values: sync, flags, fields MSB first, string, XOR.
    task automatic build_frame(input bit boo, input bit lg, input longint intv, input int int_w,
                               input longint exp_int, input longint vecv, input int vec_w,
                               input longint exp_vec, input string s, input string exp_s,
                               input real rea, input real exp_rea, output bq_t q);
        longint imask, vmask;
        bit int_ok, vec_ok, str_ok, rea_ok;
        logic [7:0] x;
        imask  = (longint'(1) << int_w) - 1;
        vmask  = (longint'(1) << vec_w) - 1;
        int_ok = ((intv & imask) == (exp_int & imask));
        vec_ok = ((vecv & vmask) == (exp_vec & vmask));
        str_ok = (s == exp_s);
        rea_ok = (rea == exp_rea);
        q = {};
        q.push_back(8'hA5);
        q.push_back({2'b00, vec_ok, int_ok, rea_ok, str_ok, lg, boo});
        for (int b = (int_w + 7) / 8 - 1; b >= 0; b--) q.push_back(8'((intv & imask) >> (8 * b)));
        for (int b = (vec_w + 7) / 8 - 1; b >= 0; b--) q.push_back(8'((vecv & vmask) >> (8 * b)));
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        q.push_back(x);
    endtask

    // Drive one frame on instance k and check every accepted byte, hold behaviour and done_o.
    task automatic run_frame(input int k, input bq_t exp, input bit rnd, input int stall_at,
                             input bit pulse_mid, input bit do_start, input bit rep, input string tag);
        int idx = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        int stall_left = 3;
        bit prev_stall = 1'b0;
        logic [7:0] prev_d = 8'h00;
        bit r;
        if (do_start) begin
            @(negedge clk); start_s[k] = 1'b1;
            @(negedge clk); start_s[k] = 1'b0;
            check_eq({tag, "_first_valid"}, 32'(tvalid_s[k]), 32'd1);
        end
        while (idx < exp.size() && cyc < 500) begin
            if (prev_stall) begin
                check_eq({tag, "_hold_valid"}, 32'(tvalid_s[k]), 32'd1);
                check_eq({tag, "_hold_data"}, 32'(tdata_s[k]), 32'(prev_d));
            end
            if (cyc > 0) check_eq({tag, "_no_done"}, 32'(done_s[k]), 32'd0);
            check_eq({tag, "_busy"}, 32'(busy_s[k]), 32'd1);
            r = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (idx == stall_at && tvalid_s[k] && stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end
            ready_s[k] = r;
            start_s[k] = (pulse_mid && idx == 3) ? 1'b1 : 1'b0;
            if (tvalid_s[k] && r) begin
                check_eq($sformatf("%s_b%0d", tag, idx), 32'(tdata_s[k]), 32'(exp[idx]));
                if (idx == 0) first = cyc;
                last = cyc;
                idx++;
            end
            prev_stall = tvalid_s[k] && !r;
            prev_d = tdata_s[k];
            cyc++;
            @(negedge clk);
        end
        start_s[k] = 1'b0;
        check_eq({tag, "_complete"}, 32'(idx), 32'(exp.size()));
        if (!rnd && stall_at < 0) check_eq({tag, "_back_to_back"}, 32'(last - first), 32'(exp.size() - 1));
        check_eq({tag, "_done"}, 32'(done_s[k]), 32'd1);
        check_eq({tag, "_done_busy"}, 32'(busy_s[k]), 32'd1);
        if (rep) begin
            check_eq({tag, "_rep_valid"}, 32'(tvalid_s[k]), 32'd1);
            check_eq({tag, "_rep_sync"}, 32'(tdata_s[k]), 32'hA5);
        end else begin
            check_eq({tag, "_done_valid"}, 32'(tvalid_s[k]), 32'd0);
            @(negedge clk);
            check_eq({tag, "_done_once"}, 32'(done_s[k]), 32'd0);
            check_eq({tag, "_idle_busy"}, 32'(busy_s[k]), 32'd0);
            @(negedge clk);
            check_eq({tag, "_not_queued"}, 32'(busy_s[k]), 32'd0);
            check_eq({tag, "_idle_valid"}, 32'(tvalid_s[k]), 32'd0);
        end
    endtask

    initial begin
        bq_t f0, f1, f2;
        f0 = {8'hA5, 8'h3F, 8'hFF, 8'hFF, 8'h57, 8'h58, 8'h59, 8'h5A, 8'h96};
        build_frame(1'b0, 1'b0, 0, 8, 255, 0, 8, 255, "ABCD", "WXYZ", 0.0, 1.1, f1);
        build_frame(1'b0, 1'b0, 'hABC, 12, 255, 0, 8, 255, "ABCD", "WXYZ", 0.0, 1.1, f2);

        rstn_s = 4'b0000; start_s = 4'b0000; ready_s = 4'b0000;
        #12;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("rst_valid%0d", k), 32'(tvalid_s[k]), 32'd0);
            check_eq($sformatf("rst_data%0d", k), 32'(tdata_s[k]), 32'd0);
            check_eq($sformatf("rst_busy%0d", k), 32'(busy_s[k]), 32'd0);
            check_eq($sformatf("rst_done%0d", k), 32'(done_s[k]), 32'd0);
        end
        check_eq("match0", 32'(match_s[0]), 32'd1);
        check_eq("match1", 32'(match_s[1]), 32'd0);
        check_eq("match2", 32'(match_s[2]), 32'd0);
        check_eq("match3", 32'(match_s[3]), 32'd1);
        @(negedge clk); rstn_s = 4'b1111;

        run_frame(0, f0, 1'b0, -1, 1'b0, 1'b1, 1'b0, "allmatch");
        run_frame(0, f0, 1'b0, 3, 1'b0, 1'b1, 1'b0, "backpressure");
        for (int i = 0; i < 3; i++) run_frame(0, f0, 1'b1, -1, 1'b1, 1'b1, 1'b0, $sformatf("rnd_match%0d", i));
        run_frame(1, f1, 1'b0, -1, 1'b0, 1'b1, 1'b0, "defaults");
        run_frame(1, f1, 1'b1, -1, 1'b1, 1'b1, 1'b0, "rnd_defaults");
        run_frame(2, f2, 1'b0, -1, 1'b0, 1'b1, 1'b0, "wide");
        run_frame(2, f2, 1'b1, -1, 1'b0, 1'b1, 1'b0, "rnd_wide");

        // Reset while byte 4 is on the bus, then a clean frame.
        @(negedge clk); ready_s[0] = 1'b1; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check_eq("midrst_byte4", 32'(tdata_s[0]), 32'(f0[4]));
        rstn_s[0] = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(tvalid_s[0]), 32'd0);
        check_eq("midrst_busy", 32'(busy_s[0]), 32'd0);
        @(negedge clk);
        check_eq("midrst_valid_hold", 32'(tvalid_s[0]), 32'd0);
        check_eq("midrst_busy_hold", 32'(busy_s[0]), 32'd0);
        rstn_s[0] = 1'b1;
        run_frame(0, f0, 1'b0, -1, 1'b0, 1'b1, 1'b0, "after_rst");

        run_frame(3, f0, 1'b0, -1, 1'b1, 1'b1, 1'b1, "repeat_a");
        run_frame(3, f0, 1'b1, -1, 1'b0, 1'b0, 1'b1, "repeat_b");
        run_frame(3, f0, 1'b0, -1, 1'b0, 1'b0, 1'b1, "repeat_c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
